// File: rtl/lfsr_rand_stream.sv
// Paces advance strobes to an external 8-bit LFSR, captures each new value and
// streams the samples out of a small reserved-slot FIFO as valid/ready bytes.
module lfsr_rand_stream #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic [7:0]                 lfsr_dout,
  output logic                       lfsr_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       stall,
  output logic                       err_zero
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            en_q;
  logic            cap_q;
  logic [LvlW-1:0] level_q;
  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic            stall_q;
  logic            err_q;
  logic [7:0]      mem_q [DEPTH];

  logic            tick;
  logic            room;
  logic            accept;
  logic            push;
  logic            pop;
  logic [LvlW:0]   resv;

  // Slots already promised to in-flight requests count against capacity.
  always_comb begin
    tick   = run && (cnt_q == CntW'(DIV - 1));
    resv   = {1'b0, level_q} + (LvlW + 1)'(en_q) + (LvlW + 1)'(cap_q);
    room   = resv < (LvlW + 1)'(DEPTH);
    accept = tick && room;
    push   = cap_q && (lfsr_dout != 8'h00);
    pop    = (level_q != '0) && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      en_q    <= 1'b0;
      cap_q   <= 1'b0;
      level_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (!run || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      en_q  <= accept;
      cap_q <= en_q;
      if (tick && !room) begin
        stall_q <= 1'b1;
      end
      if (cap_q && (lfsr_dout == 8'h00)) begin
        err_q <= 1'b1;
      end
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_q] <= lfsr_dout;
    end
  end

  assign lfsr_en   = en_q;
  assign level     = level_q;
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_q] : 8'h00;
  assign stall     = stall_q;
  assign err_zero  = err_q;

endmodule

// File: tb/tb_lfsr_rand_stream.sv
// Directed bench for lfsr_rand_stream with a Fibonacci LFSR model as the data source.
module tb_lfsr_rand_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] lfsr_dout;
  logic       lfsr_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       stall;
  logic       err_zero;

  logic [7:0] lfsr_q;
  logic       force_zero;

  int checks = 0;
  int errors = 0;
  int en_cnt;
  logic [7:0] exp_bytes [5] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
  int idx;

  lfsr_rand_stream #(.DEPTH(4), .DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .lfsr_dout (lfsr_dout),
    .lfsr_en   (lfsr_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .stall     (stall),
    .err_zero  (err_zero)
  );

  always #5 clk = ~clk;

  // Shift right, feedback from taps 0,2,3,4 enters at bit 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'h01;
    end else if (lfsr_en) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};
    end
  end

  assign lfsr_dout = force_zero ? 8'h00 : lfsr_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset(input logic ready_v);
    rst        = 1'b1;
    run        = 1'b0;
    out_ready  = ready_v;
    force_zero = 1'b0;
    step();
    step();
    rst = 1'b0;
    run = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b1;
    out_ready  = 1'b1;
    force_zero = 1'b0;
    step();
    step();
    chk("rst_en", lfsr_en, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_level", level, 3'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_err", err_zero, 1'b0);
    rst = 1'b0;
    run = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      chk("idle_en", lfsr_en, 1'b0);
    end

    // Pacing and data with free-running consumer.
    do_reset(1'b1);
    idx = 0;
    for (int n = 1; n <= 22; n++) begin
      step();
      chk("pace_en", lfsr_en, (n % 4 == 0));
      chk("pace_valid", out_valid, (n >= 6 && n % 4 == 2));
      if (n >= 6 && n % 4 == 2) begin
        chk("pace_data", out_data, exp_bytes[idx]);
        idx++;
      end
    end
    run = 1'b0;
    step();
    step();

    // Backpressure fills all slots, then drain.
    do_reset(1'b0);
    en_cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (lfsr_en) en_cnt++;
      if (n == 19) chk("bp_stall_pre", stall, 1'b0);
      if (n == 20) chk("bp_stall", stall, 1'b1);
      if (n == 24) begin
        chk("bp_en_count", en_cnt, 4);
        chk("bp_level", level, 3'd4);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_head", out_data, 8'h80);
        out_ready = 1'b1;
      end
      if (n >= 25 && n <= 27) begin
        chk("drain_data", out_data, exp_bytes[n - 24]);
        chk("drain_level", level, 3'(28 - n));
      end
      if (n == 27) chk("resume_en_lo", lfsr_en, 1'b0);
      if (n == 28) begin
        chk("resume_en", lfsr_en, 1'b1);
        chk("drain_empty", out_valid, 1'b0);
      end
      if (n == 30) begin
        chk("resume_valid", out_valid, 1'b1);
        chk("resume_data", out_data, 8'h88);
        chk("stall_sticky", stall, 1'b1);
      end
    end

    // Zero sample is discarded.
    do_reset(1'b0);
    for (int n = 1; n <= 12; n++) begin
      step();
      force_zero = 1'b0;
      if (n == 5) begin
        chk("zero_err_pre", err_zero, 1'b0);
        force_zero = 1'b1;
      end
      if (n == 6) begin
        chk("zero_err", err_zero, 1'b1);
        chk("zero_level", level, 3'd0);
        chk("zero_valid", out_valid, 1'b0);
      end
      if (n == 10) begin
        chk("zero_next_level", level, 3'd1);
        chk("zero_next_data", out_data, 8'h40);
        chk("zero_err_sticky", err_zero, 1'b1);
      end
    end

    // Dropping run while a request is in flight.
    do_reset(1'b0);
    en_cnt = 0;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n >= 5 && lfsr_en) en_cnt++;
      if (n == 4) begin
        chk("drop_en", lfsr_en, 1'b1);
        run = 1'b0;
      end
      if (n == 6) begin
        chk("drop_level", level, 3'd1);
        chk("drop_data", out_data, 8'h80);
      end
    end
    chk("drop_no_more_en", en_cnt, 0);
    chk("drop_level_hold", level, 3'd1);

    // Reset with three bytes buffered and a capture pending.
    do_reset(1'b0);
    for (int n = 1; n <= 17; n++) begin
      step();
    end
    chk("mid_level_pre", level, 3'd3);
    rst = 1'b1;
    step();
    chk("mid_level", level, 3'd0);
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_en", lfsr_en, 1'b0);
    chk("mid_data", out_data, 8'h00);
    rst = 1'b0;
    run = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
    end
    chk("mid_no_write", level, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
